// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/halfword/word load-store controller for a word-only memory, read-modify-write for sub-word stores.
// Define MEM_RANGE_CHECK_EN to reject requests whose req_addr[31:16] is nonzero.
module mem_access_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);
   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPTURE, WRITE, DONE} state_t;
   state_t state;
   logic wr, uns, bad, range_bad;
   logic [1:0] size;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata, ld_val, mask, merged;
   logic [4:0] sh;
   logic [7:0] lb;
   logic [15:0] lh;
`ifdef MEM_RANGE_CHECK_EN
   assign range_bad = |req_addr[31:ADDR_W];
`else
   logic unused_hi;
   assign unused_hi = ^req_addr[31:ADDR_W];
   assign range_bad = 1'b0;
`endif
   assign bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && |req_addr[1:0]) || range_bad;
   // Lane shift is valid for halfwords too, since an accepted halfword has addr[0]=0.
   assign sh = {addr[1:0], 3'b000};
   assign lb = 8'(mem_read_data >> sh);
   assign lh = 16'(mem_read_data >> sh);
   assign ld_val = size == 2'b00 ? {{24{~uns & lb[7]}}, lb} :
                   size == 2'b01 ? {{16{~uns & lh[15]}}, lh} : mem_read_data;
   assign mask = (size == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
   assign merged = (mem_read_data & ~mask) | ((wdata << sh) & mask);
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
         mem_write <= 1'b0;
         mem_address <= '0;
         mem_write_data <= '0;
         wr <= 1'b0;
         uns <= 1'b0;
         size <= '0;
         addr <= '0;
         wdata <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               wr <= req_write;
               size <= req_size;
               uns <= req_unsigned;
               addr <= req_addr[ADDR_W-1:0];
               wdata <= req_wdata;
               req_ready <= 1'b0;
               if (bad) begin
                  state <= DONE;
                  rsp_valid <= 1'b1;
                  rsp_error <= 1'b1;
               end else begin
                  mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
                  if (req_write && req_size == 2'b10) begin
                     state <= WRITE;
                     mem_write <= 1'b1;
                     mem_write_data <= req_wdata;
                  end else state <= RD_ISSUE;
               end
            end
            RD_ISSUE: state <= RD_CAPTURE;
            RD_CAPTURE: if (wr) begin
               state <= WRITE;
               mem_write <= 1'b1;
               mem_write_data <= merged;
            end else begin
               state <= DONE;
               rsp_valid <= 1'b1;
               rsp_rdata <= ld_val;
            end
            WRITE: begin
               state <= DONE;
               mem_write <= 1'b0;
               rsp_valid <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               rsp_valid <= 1'b0;
               rsp_error <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl against a byte-addressed reference memory.
module tb_mem_access_ctrl;
   logic clock = 1'b0, reset = 1'b1;
   logic req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
   logic [1:0] req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic req_ready, rsp_valid, rsp_error, mem_write;
   logic [31:0] rsp_rdata, mem_write_data, mem_read_data;
   logic [15:0] mem_address;
   logic [31:0] mem [16384];
   logic [31:0] ref_mem [16384];
   logic [15:0] wr_addr;
   logic [31:0] wr_data;
   int checks = 0, fails = 0, wr_cnt = 0;

   always #5 clock = ~clock;

   mem_access_ctrl dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .mem_write(mem_write),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   // Word memory with one-cycle registered read, plus a write monitor.
   always @(posedge clock) begin
      if (mem_write) begin
         mem[mem_address[15:2]] <= mem_write_data;
         wr_cnt <= wr_cnt + 1;
         wr_addr <= mem_address;
         wr_data <= mem_write_data;
      end
      mem_read_data <= mem[mem_address[15:2]];
   end

   function automatic logic ref_bad(logic [1:0] sz, logic [31:0] a);
      logic b;
      b = sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
`ifdef MEM_RANGE_CHECK_EN
      if (a >= 32'h10000) b = 1'b1;
`endif
      return b;
   endfunction

   function automatic int nbytes(logic [1:0] sz);
      return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
   endfunction

   function automatic void ref_store(logic [1:0] sz, logic [31:0] a, logic [31:0] d);
      int unsigned b;
      for (int k = 0; k < nbytes(sz); k++) begin
         b = (a + k) % 65536;
         ref_mem[b / 4][8 * (b % 4) +: 8] = d[8 * k +: 8];
      end
   endfunction

   function automatic logic [31:0] ref_load(logic [1:0] sz, logic u, logic [31:0] a);
      longint v = 0;
      int unsigned b;
      int nb = nbytes(sz);
      for (int k = nb - 1; k >= 0; k--) begin
         b = (a + k) % 65536;
         v = v * 256 + longint'(ref_mem[b / 4][8 * (b % 4) +: 8]);
      end
      if (!u && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      return 32'(v);
   endfunction

   function automatic int ref_lat(logic w, logic [1:0] sz, logic [31:0] a);
      return ref_bad(sz, a) ? 1 : !w ? 3 : sz == 2'd2 ? 2 : 4;
   endfunction

   // Present one request, scramble req_* after acceptance, and measure latency to rsp_valid.
   task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
      int n = 0;
      @(negedge clock);
      while (!req_ready && n < 10) begin
         @(negedge clock);
         n++;
      end
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
      @(posedge clock);
      #1;
      req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 12) begin
         @(posedge clock);
         #1;
         lat++;
      end
      rd = rsp_rdata;
      er = rsp_error;
      if (!rsp_valid) lat = 99;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (mem_write !== 1'b0) begin fails++; $display("FAIL rst_mem_write: got %b expected 0", mem_write); end
      checks++; if ({rsp_error, rsp_rdata, mem_address, mem_write_data} !== 81'd0)
         begin fails++; $display("FAIL rst_data: got err=%b rd=%h ma=%h wd=%h expected all 0", rsp_error, rsp_rdata, mem_address, mem_write_data); end
      reset = 1'b0;
   endtask

   task automatic test_word;
      logic [31:0] rd; logic er; int lat, n0;
      n0 = wr_cnt;
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, rd, er, lat);
      ref_store(2'd2, 32'h10, 32'h12345678);
      checks++; if (lat !== 2) begin fails++; $display("FAIL wst_lat: got %0d expected 2", lat); end
      checks++; if (wr_cnt - n0 !== 1) begin fails++; $display("FAIL wst_count: got %0d expected 1", wr_cnt - n0); end
      checks++; if ({wr_addr, wr_data} !== {16'h0010, 32'h12345678}) begin fails++; $display("FAIL wst_write: got %h/%h expected 0010/12345678", wr_addr, wr_data); end
      n0 = wr_cnt;
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
      checks++; if (lat !== 3) begin fails++; $display("FAIL wld_lat: got %0d expected 3", lat); end
      checks++; if ({er, rd} !== {1'b0, 32'h12345678}) begin fails++; $display("FAIL wld_data: got %b/%h expected 0/12345678", er, rd); end
      @(posedge clock);
      #1;
      checks++; if ({rsp_valid, rsp_rdata, req_ready} !== {1'b0, 32'h0, 1'b1}) begin fails++; $display("FAIL wld_after: got v=%b rd=%h rdy=%b expected 0/0/1", rsp_valid, rsp_rdata, req_ready); end
      checks++; if (wr_cnt !== n0) begin fails++; $display("FAIL wld_nowrite: got %0d writes expected 0", wr_cnt - n0); end
   endtask

   task automatic test_subword_store;
      logic [31:0] rd; logic er; int lat, n0;
      do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hAABBCCDD, rd, er, lat);
      ref_store(2'd2, 32'h20, 32'hAABBCCDD);
      n0 = wr_cnt;
      do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'hFFFFFF5E, rd, er, lat);
      ref_store(2'd0, 32'h22, 32'hFFFFFF5E);
      checks++; if (lat !== 4) begin fails++; $display("FAIL bst_lat: got %0d expected 4", lat); end
      checks++; if (wr_cnt - n0 !== 1) begin fails++; $display("FAIL bst_count: got %0d expected 1", wr_cnt - n0); end
      checks++; if ({wr_addr, wr_data} !== {16'h0020, 32'hAA5ECCDD}) begin fails++; $display("FAIL bst_write: got %h/%h expected 0020/aa5eccdd", wr_addr, wr_data); end
      checks++; if ({er, rd} !== 33'd0) begin fails++; $display("FAIL bst_rsp: got %b/%h expected 0/0", er, rd); end
   endtask

   task automatic test_loads;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h0000005E) begin fails++; $display("FAIL lb_signed: got %h expected 0000005e", rd); end
      do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'hFFFFAA5E) begin fails++; $display("FAIL lh_signed: got %h expected ffffaa5e", rd); end
      do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h0000AA5E) begin fails++; $display("FAIL lh_unsigned: got %h expected 0000aa5e", rd); end
      do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'hFFFFFFCC) begin fails++; $display("FAIL lb_neg: got %h expected ffffffcc", rd); end
   endtask

   task automatic test_errors;
      logic [31:0] rd; logic er; int lat, n0;
      do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, rd, er, lat);
      ref_store(2'd2, 32'h30, 32'hCAFEF00D);
      n0 = wr_cnt;
      do_req(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, rd, er, lat);
      checks++; if ({er, rd, 8'(lat)} !== {1'b1, 32'h0, 8'd1}) begin fails++; $display("FAIL err_half: got e=%b rd=%h lat=%0d expected 1/0/1", er, rd, lat); end
      do_req(1'b1, 2'd2, 1'b0, 32'h32, 32'hFFFFFFFF, rd, er, lat);
      checks++; if ({er, 8'(lat)} !== {1'b1, 8'd1}) begin fails++; $display("FAIL err_word: got e=%b lat=%0d expected 1/1", er, lat); end
      do_req(1'b1, 2'd3, 1'b0, 32'h30, 32'h0, rd, er, lat);
      checks++; if ({er, 8'(lat)} !== {1'b1, 8'd1}) begin fails++; $display("FAIL err_size: got e=%b lat=%0d expected 1/1", er, lat); end
      checks++; if (wr_cnt !== n0) begin fails++; $display("FAIL err_nowrite: got %0d writes expected 0", wr_cnt - n0); end
      do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat);
      checks++; if (rd !== ref_load(2'd2, 1'b0, 32'h30)) begin fails++; $display("FAIL err_mem: got %h expected %h", rd, ref_load(2'd2, 1'b0, 32'h30)); end
   endtask

   task automatic test_reset_midop;
      logic [31:0] rd; logic er; int lat, n0;
      n0 = wr_cnt;
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h21; req_wdata = 32'h77;
      @(posedge clock);
      #1 req_valid = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
      checks++; if (mem_write !== 1'b0) begin fails++; $display("FAIL rmid_mem_write: got %b expected 0", mem_write); end
      checks++; if ({req_ready, rsp_valid, rsp_error, rsp_rdata, mem_address, mem_write_data} !== {1'b1, 82'd0})
         begin fails++; $display("FAIL rmid_outputs: got rdy=%b v=%b e=%b rd=%h ma=%h wd=%h expected reset values", req_ready, rsp_valid, rsp_error, rsp_rdata, mem_address, mem_write_data); end
      reset = 1'b0;
      @(posedge clock);
      #1;
      checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready: got %b expected 1", req_ready); end
      repeat (4) @(posedge clock);
      #1;
      checks++; if (wr_cnt !== n0) begin fails++; $display("FAIL rmid_nowrite: got %0d writes expected 0", wr_cnt - n0); end
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
      checks++; if (rd !== ref_load(2'd2, 1'b0, 32'h20)) begin fails++; $display("FAIL rmid_mem: got %h expected %h", rd, ref_load(2'd2, 1'b0, 32'h20)); end
   endtask

   task automatic test_range;
      logic [31:0] rd, d; logic er; int lat;
      d = $urandom;
      do_req(1'b1, 2'd2, 1'b0, 32'h4, d, rd, er, lat);
      ref_store(2'd2, 32'h4, d);
      do_req(1'b0, 2'd2, 1'b0, 32'h00010004, 32'h0, rd, er, lat);
`ifdef MEM_RANGE_CHECK_EN
      checks++; if ({er, rd, 8'(lat)} !== {1'b1, 32'h0, 8'd1}) begin fails++; $display("FAIL range: got e=%b rd=%h lat=%0d expected 1/0/1", er, rd, lat); end
`else
      checks++; if ({er, rd, 8'(lat)} !== {1'b0, d, 8'd3}) begin fails++; $display("FAIL range: got e=%b rd=%h lat=%0d expected 0/%h/3", er, rd, lat, d); end
`endif
   endtask

   task automatic test_random;
      logic [31:0] rd, a, d, exp_rd; logic er, w, u; logic [1:0] sz; int lat, n0, exp_lat;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         do_req(1'b1, 2'd2, 1'b0, 32'h100 + 4 * i, d, rd, er, lat);
         ref_store(2'd2, 32'h100 + 4 * i, d);
      end
      for (int i = 0; i < 60; i++) begin
         w = 1'($urandom); sz = 2'($urandom); u = 1'($urandom);
         a = 32'h100 + $urandom_range(0, 31); d = $urandom;
         exp_lat = ref_lat(w, sz, a);
         exp_rd = (w || ref_bad(sz, a)) ? 32'h0 : ref_load(sz, u, a);
         n0 = wr_cnt;
         do_req(w, sz, u, a, d, rd, er, lat);
         if (w && !ref_bad(sz, a)) ref_store(sz, a, d);
         checks++;
         if ({er, rd, 8'(lat)} !== {ref_bad(sz, a), exp_rd, 8'(exp_lat)})
            begin fails++; $display("FAIL rand%0d w=%b sz=%0d a=%h: got e=%b rd=%h lat=%0d expected e=%b rd=%h lat=%0d", i, w, sz, a, er, rd, lat, ref_bad(sz, a), exp_rd, exp_lat); end
         checks++;
         if (wr_cnt - n0 !== int'(w && !ref_bad(sz, a)) || (wr_cnt != n0 && wr_data !== ref_mem[a[15:2]]))
            begin fails++; $display("FAIL rand%0d_write: got %0d writes data %h expected %0d writes data %h", i, wr_cnt - n0, wr_data, int'(w && !ref_bad(sz, a)), ref_mem[a[15:2]]); end
      end
   endtask

   initial begin
      test_reset;
      test_word;
      test_subword_store;
      test_loads;
      test_errors;
      test_reset_midop;
      test_range;
      test_random;
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
